fault_inj_ctrl: RTL and testbench
=================================

Name: fault_inj_ctrl

Overview:
Synthesizable, parametrised fault-injection controller for redundancy/lockstep experiments on the SoC. Sits inline on CHANNELS datapath buses (e.g. primary CPU ALU result) and, once armed and triggered, corrupts one selected channel for a programmed window after a programmed delay. It replaces bench-only force/release injection with a repeatable, cycle-exact block that also supports stuck-at-1, bit-flip and pseudo-random corruption.

Parameters:
WIDTH, 32, bits per channel
CHANNELS, 4, number of inline buses (1..16)
CNT_W, 16, width of delay/duration counters
LFSR_SEED, 32'hACE1_2468, reset value of the random-mode LFSR (must be nonzero)

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
arm  in  1  single-cycle pulse; latches cfg_* when in IDLE
abort  in  1  level; forces return to IDLE
trigger  in  1  level; starts delay countdown when ARMED (e.g. is_redundant)
cfg_chan  in  4  target channel index
cfg_mode  in  2  00 stuck-at-0, 01 stuck-at-1, 10 bit-flip, 11 random
cfg_mask  in  WIDTH  bits subject to corruption
cfg_delay  in  CNT_W  cycles from trigger to first corrupted cycle
cfg_duration  in  CNT_W  corrupted cycles
sig_in  in  CHANNELS*WIDTH  clean buses, channel k at [k*WIDTH +: WIDTH]
sig_out  out  CHANNELS*WIDTH  possibly-corrupted buses
active  out  1  high while corruption applied
done  out  1  one-cycle pulse at end of an injection sequence
cfg_err  out  1  one-cycle pulse: arm with cfg_chan >= CHANNELS
inj_count  out  8  saturating count of completed injections

Behaviour:
- Reset (async, rstn low): state IDLE, active 0, done 0, cfg_err 0, inj_count 0, LFSR = LFSR_SEED, latched config 0; sig_out == sig_in.
- sig_out combinational: all channels pass through except latched channel while state INJECT. Corrupted word: mode 00 in & ~mask; 01 in | mask; 10 in ^ mask; 11 in ^ (lfsr & mask). Zero added latency.
- States: IDLE, ARMED, DELAY, INJECT, DONE.
- IDLE: arm && cfg_chan < CHANNELS -> latch cfg_*, go ARMED. arm && cfg_chan >= CHANNELS -> cfg_err pulse next cycle, stay IDLE. arm outside IDLE ignored.
- ARMED: trigger high -> cnt = cfg_delay; go DELAY if cfg_delay != 0, else INJECT (first corrupted cycle is the cycle after trigger sampled). Delay d >= 1: first corrupted cycle is d+1 cycles after trigger sampled.
- DELAY: decrement cnt; when cnt reaches 1 go INJECT, cnt = duration.
- INJECT: active 1; exactly cfg_duration consecutive corrupted cycles, then DONE. cfg_duration == 0: ARMED/DELAY go directly to DONE, no corruption.
- DONE: one cycle; done = 1, inj_count += 1 saturating at 255; next IDLE.
- trigger dropping after leaving ARMED does not stop the sequence.
- abort (any state, highest priority): next state IDLE, active 0 in the following cycle, no done pulse, inj_count unchanged.
- LFSR: 32-bit Galois, taps x^32+x^22+x^2+x+1, advances every cycle in INJECT only; upper bits unused when WIDTH < 32, replicated when WIDTH > 32.
- done, cfg_err, active registered outputs.

Decomposition:
- Package fault_inj_pkg: state enum, mode encodings (FI_STUCK0, FI_STUCK1, FI_FLIP, FI_RAND), LFSR tap constant.
- Sub-module fi_lfsr (enable, 32-bit state, parametrised seed), kept separate for reuse by other injectors.

Test Plan:
- Reset passthrough: rstn low, sig_in ch0=32'h1234_5678 -> sig_out identical, active 0, inj_count 0.
- Stuck-at-0: chan 0, mode 00, mask FFFF_FFFF, delay 15, duration 10, trigger at cycle T -> ch0 = 0 exactly cycles T+16..T+25, other channels untouched, done at T+26, inj_count 1.
- Bit-flip zero delay: chan 2, mode 10, mask 0000_0001, delay 0, duration 1, sig_in ch2 = 5 -> ch2 = 4 on cycle T+1 only.
- Duration 0 and bad channel: duration 0 -> done pulse, active never high; arm with cfg_chan=7 (CHANNELS=4) -> cfg_err pulse, state stays IDLE.
- Abort mid-inject: duration 20, abort after 5 corrupted cycles -> passthrough next cycle, no done, inj_count unchanged; rearm works.
- Random mode + saturation: mode 11, mask 0000_00FF -> only low byte differs, upper 24 bits equal sig_in; 260 sequences -> inj_count holds 255.

Source files
------------

// File: rtl/fault_inj_pkg.sv
// Shared types and constants for the inline fault-injection controller
// and its pseudo-random source.
package fault_inj_pkg;

  localparam int          FI_LFSR_W    = 32;
  // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
  localparam logic [31:0] FI_LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    FI_STUCK0 = 2'b00,
    FI_STUCK1 = 2'b01,
    FI_FLIP   = 2'b10,
    FI_RAND   = 2'b11
  } fi_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_DELAY,
    ST_INJECT,
    ST_DONE
  } fi_state_e;

  function automatic logic [FI_LFSR_W-1:0] lfsr_step(input logic [FI_LFSR_W-1:0] s);
    return s[0] ? ((s >> 1) ^ FI_LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/fi_lfsr.sv
// 32-bit Galois LFSR that advances only when enabled; shared by the
// fault injectors as their random corruption source.
module fi_lfsr
  import fault_inj_pkg::*;
#(
  parameter logic [FI_LFSR_W-1:0] SEED = 32'hACE1_2468
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  output logic [FI_LFSR_W-1:0] state
);

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= SEED;
    end else if (en) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/fault_inj_ctrl.sv
// Inline fault-injection controller: once armed and triggered, corrupts one
// selected channel for a programmed window after a programmed delay.
module fault_inj_ctrl
  import fault_inj_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter int          CHANNELS  = 4,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      arm,
  input  logic                      abort,
  input  logic                      trigger,
  input  logic [3:0]                cfg_chan,
  input  logic [1:0]                cfg_mode,
  input  logic [WIDTH-1:0]          cfg_mask,
  input  logic [CNT_W-1:0]          cfg_delay,
  input  logic [CNT_W-1:0]          cfg_duration,
  input  logic [CHANNELS*WIDTH-1:0] sig_in,
  output logic [CHANNELS*WIDTH-1:0] sig_out,
  output logic                      active,
  output logic                      done,
  output logic                      cfg_err,
  output logic [7:0]                inj_count
);

  typedef struct packed {
    logic [3:0]       chan;
    fi_mode_e         mode;
    logic [WIDTH-1:0] mask;
    logic [CNT_W-1:0] delay;
    logic [CNT_W-1:0] duration;
  } cfg_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  fi_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  cfg_t                 cfg_q, cfg_d;
  logic                 err_d;
  logic                 chan_ok;
  logic [FI_LFSR_W-1:0] lfsr_state;
  logic [WIDTH-1:0]     rnd_word;

  fi_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rstn  (rstn),
    .en    (state_q == ST_INJECT),
    .state (lfsr_state)
  );

  assign chan_ok = (32'(cfg_chan) < CHANNELS);

  // Narrow buses take the low LFSR bits; wide buses repeat the 32-bit pattern.
  always_comb begin
    rnd_word = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rnd_word[i] = lfsr_state[i % FI_LFSR_W];
    end
  end

  function automatic logic [WIDTH-1:0] corrupt(input logic [WIDTH-1:0] w,
                                               input fi_mode_e         mode,
                                               input logic [WIDTH-1:0] mask,
                                               input logic [WIDTH-1:0] rnd);
    case (mode)
      FI_STUCK0: return w & ~mask;
      FI_STUCK1: return w | mask;
      FI_FLIP:   return w ^ mask;
      default:   return w ^ (rnd & mask);
    endcase
  endfunction

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it holding a value (no latch inferred).
  always_comb begin
    sig_out = sig_in;
    for (int k = 0; k < CHANNELS; k++) begin
      if (state_q == ST_INJECT && cfg_q.chan == 4'(k)) begin
        sig_out[k*WIDTH +: WIDTH] = corrupt(sig_in[k*WIDTH +: WIDTH], cfg_q.mode,
                                            cfg_q.mask, rnd_word);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cfg_d   = cfg_q;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          if (chan_ok) begin
            cfg_d.chan     = cfg_chan;
            cfg_d.mode     = fi_mode_e'(cfg_mode);
            cfg_d.mask     = cfg_mask;
            cfg_d.delay    = cfg_delay;
            cfg_d.duration = cfg_duration;
            state_d        = ST_ARMED;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_ARMED: begin
        if (trigger) begin
          if (cfg_q.delay != '0) begin
            state_d = ST_DELAY;
            cnt_d   = cfg_q.delay;
          end else if (cfg_q.duration != '0) begin
            state_d = ST_INJECT;
            cnt_d   = cfg_q.duration;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      // cnt == 1 marks the last delay cycle, so injection starts d+1 cycles
      // after the trigger was sampled.
      ST_DELAY: begin
        if (cnt_q == CNT_ONE) begin
          if (cfg_q.duration != '0) begin
            state_d = ST_INJECT;
            cnt_d   = cfg_q.duration;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_INJECT: begin
        if (cnt_q == CNT_ONE) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d = ST_IDLE;
      cfg_d   = cfg_q;
      err_d   = 1'b0;
    end
  end

  // Status outputs are derived from the next state so they line up exactly
  // with the state they describe while still coming straight from flops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cfg_q     <= '0;
      active    <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      inj_count <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cfg_q   <= cfg_d;
      active  <= (state_d == ST_INJECT);
      done    <= (state_d == ST_DONE);
      cfg_err <= err_d;
      if (state_d == ST_DONE && inj_count != 8'hFF) begin
        inj_count <= inj_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fault_inj_ctrl.sv
// Directed bench for fault_inj_ctrl: table of injection sequences plus
// hand-written reset, bad-channel, abort, random-mode and saturation cases.
module tb_fault_inj_ctrl;

  localparam int W   = 32;
  localparam int CH  = 4;
  localparam int CW  = 16;
  localparam int BUS = W * CH;

  localparam logic [BUS-1:0] CLEAN = {32'hDEAD_BEEF, 32'h0000_0005,
                                      32'hA5A5_5A5A, 32'h1234_5678};

  logic           clk = 1'b0;
  logic           rstn, arm, abort, trigger;
  logic [3:0]     cfg_chan;
  logic [1:0]     cfg_mode;
  logic [W-1:0]   cfg_mask;
  logic [CW-1:0]  cfg_delay, cfg_duration;
  logic [BUS-1:0] sig_in, sig_out;
  logic           active, done, cfg_err;
  logic [7:0]     inj_count;

  int n_tests   = 0;
  int n_fail    = 0;
  int exp_count = 0;
  logic [W-1:0] rnd_exp[$];

  typedef struct {
    logic [3:0]   chan;
    logic [1:0]   mode;
    logic [W-1:0] mask;
    int           delay;
    int           duration;
    logic [W-1:0] word;
  } vec_t;

  vec_t vecs[8];

  fault_inj_ctrl #(
    .WIDTH(W), .CHANNELS(CH), .CNT_W(CW), .LFSR_SEED(32'hACE1_2468)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .arm          (arm),
    .abort        (abort),
    .trigger      (trigger),
    .cfg_chan     (cfg_chan),
    .cfg_mode     (cfg_mode),
    .cfg_mask     (cfg_mask),
    .cfg_delay    (cfg_delay),
    .cfg_duration (cfg_duration),
    .sig_in       (sig_in),
    .sig_out      (sig_out),
    .active       (active),
    .done         (done),
    .cfg_err      (cfg_err),
    .inj_count    (inj_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [BUS-1:0] act,
                       input logic [BUS-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Arms, triggers for one cycle, then walks every cycle up to the one after
  // the done pulse. Cycle i=1 is the cycle following the trigger sample.
  task automatic run_seq(input vec_t v);
    int             last;
    logic           corrupt;
    logic [BUS-1:0] exp_bus;
    logic [W-1:0]   w;
    cfg_chan     = v.chan;
    cfg_mode     = v.mode;
    cfg_mask     = v.mask;
    cfg_delay    = CW'(v.delay);
    cfg_duration = CW'(v.duration);
    arm          = 1'b1;
    step();
    arm     = 1'b0;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    last = v.delay + v.duration + 1;
    for (int i = 1; i <= last + 1; i++) begin
      corrupt = (i >= v.delay + 1) && (i <= v.delay + v.duration);
      exp_bus = CLEAN;
      if (corrupt) begin
        if (v.mode == 2'b11) w = (rnd_exp.size() > 0) ? rnd_exp.pop_front() : 'x;
        else                 w = v.word;
        exp_bus[v.chan*W +: W] = w;
      end
      check($sformatf("bus c%0d", i), sig_out, exp_bus);
      check($sformatf("active c%0d", i), BUS'(active), BUS'(corrupt));
      check($sformatf("done c%0d", i), BUS'(done), BUS'(i == last));
      if (i == last) begin
        if (exp_count < 255) exp_count++;
        check("inj_count", BUS'(inj_count), BUS'(exp_count));
      end
      step();
    end
  endtask

  task automatic check_reset_state();
    check("rst sig_out", sig_out, CLEAN);
    check("rst active", BUS'(active), '0);
    check("rst done", BUS'(done), '0);
    check("rst cfg_err", BUS'(cfg_err), '0);
    check("rst inj_count", BUS'(inj_count), '0);
  endtask

  initial begin
    int   done_seen;
    vec_t v;
    logic [3:0] bad_chans[2];

    rstn = 1'b0; arm = 1'b0; abort = 1'b0; trigger = 1'b0;
    cfg_chan = '0; cfg_mode = '0; cfg_mask = '0;
    cfg_delay = '0; cfg_duration = '0;
    sig_in = CLEAN;

    //          chan  mode   mask           dly dur  corrupted word
    vecs[0] = '{4'd0, 2'b00, 32'hFFFF_FFFF, 15, 10, 32'h0000_0000};
    vecs[1] = '{4'd2, 2'b10, 32'h0000_0001,  0,  1, 32'h0000_0004};
    vecs[2] = '{4'd1, 2'b01, 32'h0000_FFFF,  1,  2, 32'hA5A5_FFFF};
    vecs[3] = '{4'd3, 2'b10, 32'hFFFF_0000,  3,  3, 32'h2152_BEEF};
    vecs[4] = '{4'd3, 2'b00, 32'h0F0F_0F0F,  2,  4, 32'hD0A0_B0E0};
    vecs[5] = '{4'd1, 2'b01, 32'hFFFF_FFFF,  0,  0, 32'hA5A5_5A5A};
    vecs[6] = '{4'd0, 2'b10, 32'hFFFF_FFFF,  4,  0, 32'h1234_5678};
    vecs[7] = '{4'd2, 2'b01, 32'h8000_0000,  0,  3, 32'h8000_0005};

    #12;
    check_reset_state();
    rstn = 1'b1;
    step();

    for (int n = 0; n < 8; n++) begin
      run_seq(vecs[n]);
    end

    // Out-of-range channel: error pulse, controller must not leave IDLE.
    bad_chans[0] = 4'd7;
    bad_chans[1] = 4'd4;
    for (int b = 0; b < 2; b++) begin
      cfg_chan = bad_chans[b]; cfg_mode = 2'b10; cfg_mask = '1;
      cfg_delay = '0; cfg_duration = CW'(1);
      arm = 1'b1;
      step();
      arm = 1'b0;
      check($sformatf("cfg_err ch%0d", bad_chans[b]), BUS'(cfg_err), BUS'(1'b1));
      trigger = 1'b1;
      step();
      check("cfg_err pulse width", BUS'(cfg_err), '0);
      for (int i = 0; i < 3; i++) begin
        step();
        check("bad chan active", BUS'(active), '0);
        check("bad chan done", BUS'(done), '0);
        check("bad chan sig_out", sig_out, CLEAN);
      end
      trigger = 1'b0;
      step();
    end

    // Abort after five corrupted cycles of a twenty-cycle window.
    v = '{4'd1, 2'b10, 32'hFFFF_FFFF, 0, 20, 32'h5A5A_A5A5};
    cfg_chan = v.chan; cfg_mode = v.mode; cfg_mask = v.mask;
    cfg_delay = '0; cfg_duration = CW'(20);
    arm = 1'b1;
    step();
    arm = 1'b0;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("abort pre bus c%0d", i), sig_out,
            {CLEAN[BUS-1:2*W], 32'h5A5A_A5A5, CLEAN[W-1:0]});
      check($sformatf("abort pre active c%0d", i), BUS'(active), BUS'(1'b1));
      if (i < 5) step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort passthrough", sig_out, CLEAN);
    check("abort active", BUS'(active), '0);
    done_seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (done === 1'b1 || active === 1'b1) done_seen++;
      step();
    end
    check("abort no done/active", BUS'(done_seen), '0);
    check("abort inj_count", BUS'(inj_count), BUS'(exp_count));
    v.duration = 2;
    run_seq(v);

    // Mid-run reset returns everything, including the LFSR, to its reset value.
    rstn = 1'b0;
    #1;
    check_reset_state();
    rstn = 1'b1;
    exp_count = 0;
    step();

    // Random mode, low byte only; words derived by hand from the seed.
    rnd_exp = '{32'h1234_5610, 32'h1234_564C, 32'h1234_5662,
                32'h1234_56F5, 32'h1234_563D, 32'h1234_5659};
    run_seq('{4'd0, 2'b11, 32'h0000_00FF, 0, 6, 32'h0});
    check("rnd words consumed", BUS'(rnd_exp.size()), '0);
    // LFSR must hold while idle and delaying.
    rnd_exp = '{32'h1234_56EB};
    run_seq('{4'd0, 2'b11, 32'h0000_00FF, 3, 1, 32'h0});

    // 260 more completed sequences: count saturates at 255.
    for (int n = 0; n < 260; n++) begin
      run_seq(vecs[5]);
    end
    check("inj_count saturated", BUS'(inj_count), BUS'(8'd255));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
